capture_bank: RTL

CAPTURE_BANK -- requirements
Module: capture_bank

---
 rtl/capture_pkg.sv | 31 +++
 rtl/capture_bank_channel.sv | 130 +++++++++++++
 rtl/capture_bank.sv | 51 +++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types and default sizing for the capture bank.
// Edge-mode encoding matches the two-bit edge_mode field per channel.
// No logic; no latency or backpressure.
package capture_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int CH_DEF        = 2;
  localparam int FLT_WIDTH_DEF = 4;
  localparam int TS_WIDTH_DEF  = 24;
  localparam int DEPTH_DEF     = 3;

  function automatic logic edge_qualifies(input edge_mode_e mode, input logic rise,
                                          input logic fall);
    logic q;
    q = 1'b0;
    case (mode)
      EDGE_RISE: q = rise;
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/capture_bank_channel.sv
// One channel: glitch filter, edge qualify, timestamp history (period with CAPTURE_BANK_PERIOD_EN).
// Latency: filtered d->out flt_val+1 cycles; capture one cycle after the edge is seen.
// No backpressure: ena freezes the channel, clr flushes it.
module capture_bank_channel
  import capture_pkg::*;
#(
  parameter int FLT_WIDTH = FLT_WIDTH_DEF,
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      filt_ena,
  input  logic                      d,
  input  logic [FLT_WIDTH-1:0]      flt_val,
  input  edge_mode_e                edge_mode,
  input  logic [TS_WIDTH-1:0]       timestamp,
  input  logic                      clr,
  output logic                      filtered,
  output logic                      cap_stb,
  output logic [DEPTH*TS_WIDTH-1:0] cap_ts,
  output logic                      valid,
  output logic [TS_WIDTH-1:0]       period
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [FLT_WIDTH-1:0]           flt_cnt_q, flt_cnt_d;
  logic                           filtered_q, filtered_d;
  logic                           filt_dly_q, filt_dly_d;
  logic [DEPTH-1:0][TS_WIDTH-1:0] hist_q, hist_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           cap_stb_q, cap_stb_d;
  logic                           rise, fall, capture;

  // Counter also restarts on the cycle filtered flips so a stale full count
  // cannot let the very next disagreement through unfiltered.
  always_comb begin
    flt_cnt_d  = flt_cnt_q;
    filtered_d = filtered_q;
    if (d == filtered_q) begin
      flt_cnt_d = '0;
    end else if (flt_cnt_q >= flt_val) begin
      if (ena) begin
        filtered_d = d;
        flt_cnt_d  = '0;
      end
    end else if (filt_ena) begin
      flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  always_comb begin
    filt_dly_d = ena ? filtered_q : filt_dly_q;
    rise       = filtered_q & ~filt_dly_q;
    fall       = ~filtered_q & filt_dly_q;
    capture    = ena & edge_qualifies(edge_mode, rise, fall) & ~clr;
  end

  always_comb begin
    hist_d    = hist_q;
    count_d   = count_q;
    cap_stb_d = 1'b0;
    if (clr) begin
      hist_d  = '0;
      count_d = '0;
    end else if (capture) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        hist_d[k] = hist_q[k-1];
      end
      hist_d[0] = timestamp;
      cap_stb_d = 1'b1;
      if (count_q != CNT_FULL) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt_q  <= '0;
      filtered_q <= 1'b0;
      filt_dly_q <= 1'b0;
      hist_q     <= '0;
      count_q    <= '0;
      cap_stb_q  <= 1'b0;
    end else begin
      flt_cnt_q  <= flt_cnt_d;
      filtered_q <= filtered_d;
      filt_dly_q <= filt_dly_d;
      hist_q     <= hist_d;
      count_q    <= count_d;
      cap_stb_q  <= cap_stb_d;
    end
  end

`ifdef CAPTURE_BANK_PERIOD_EN
  logic [TS_WIDTH-1:0] period_q, period_d;

  // New slot1 is the old slot0, so the difference needs at least one prior capture.
  always_comb begin
    period_d = period_q;
    if (clr) begin
      period_d = '0;
    end else if (capture) begin
      period_d = (count_q != '0) ? (timestamp - hist_q[0]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  assign period = period_q;
`else
  assign period = '0;
`endif

  assign filtered = filtered_q;
  assign cap_stb  = cap_stb_q;
  assign cap_ts   = hist_q;
  assign valid    = (count_q == CNT_FULL);

endmodule

// File: rtl/capture_bank.sv
// Bank of CH independent filtered input-capture channels; period output live with CAPTURE_BANK_PERIOD_EN.
// Latency: capture strobe and history one cycle after a qualified filtered edge.
// No backpressure: captures are never stalled, ena gates all channels.
module capture_bank
  import capture_pkg::*;
#(
  parameter int CH        = CH_DEF,
  parameter int FLT_WIDTH = FLT_WIDTH_DEF,
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic                         filt_ena,
  input  logic [CH-1:0]                d,
  input  logic [CH*FLT_WIDTH-1:0]      flt_val,
  input  logic [CH*2-1:0]              edge_mode,
  input  logic [TS_WIDTH-1:0]          timestamp,
  input  logic [CH-1:0]                clr,
  output logic [CH-1:0]                filtered,
  output logic [CH-1:0]                cap_stb,
  output logic [CH*DEPTH*TS_WIDTH-1:0] cap_ts,
  output logic [CH-1:0]                valid,
  output logic [CH*TS_WIDTH-1:0]       period
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    capture_bank_channel #(
      .FLT_WIDTH(FLT_WIDTH),
      .TS_WIDTH (TS_WIDTH),
      .DEPTH    (DEPTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .filt_ena (filt_ena),
      .d        (d[i]),
      .flt_val  (flt_val[i*FLT_WIDTH +: FLT_WIDTH]),
      .edge_mode(edge_mode_e'(edge_mode[i*2 +: 2])),
      .timestamp(timestamp),
      .clr      (clr[i]),
      .filtered (filtered[i]),
      .cap_stb  (cap_stb[i]),
      .cap_ts   (cap_ts[i*DEPTH*TS_WIDTH +: DEPTH*TS_WIDTH]),
      .valid    (valid[i]),
      .period   (period[i*TS_WIDTH +: TS_WIDTH])
    );
  end

endmodule
